// File: rtl/smart_sys_pkg.sv
// Shared definitions for the output-stationary systolic tile.
//   - state_t      : tile control FSM encoding
//   - flush_len    : number of zero-injection cycles to empty the skewed array
//   - lane_lsb     : LSB position of a lane inside a packed lane bus
//   - acc_max_fn / acc_min_fn : signed saturation limits for a given
//     accumulator width (used when SMART_SYS_ACC_SAT_EN is defined)
package smart_sys_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // The last beat enters lane 0 and needs (rows-1)+(cols-1) further
    // enabled cycles to reach PE(rows-1, cols-1), plus the cycle that
    // accumulates there.
    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // Limits are built at a fixed 128-bit width and sliced by the user.
    function automatic logic [127:0] acc_max_fn(input int w);
        logic [127:0] one;
        one = 128'd1;
        return (one << (w - 1)) - one;
    endfunction

    function automatic logic [127:0] acc_min_fn(input int w);
        logic [127:0] one;
        one = 128'd1;
        return one << (w - 1);
    endfunction

endpackage

// File: rtl/smart_sys_os_pe.sv
// One output-stationary processing element.
//   clk, rst   : clock, asynchronous active-low reset
//   en         : array enable; with en low every register holds
//   clr        : synchronous clear of accumulator and forward registers
//   a_in/b_in  : left / top operands (signed)
//   a_out/b_out: registered operands forwarded right / down
//   acc        : running accumulator
//   sat        : (SMART_SYS_ACC_SAT_EN only) this cycle's accumulate clipped
module smart_sys_os_pe
    import smart_sys_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ACC_SIZE  = 40
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clr,
    input  logic signed [WORD_SIZE-1:0] a_in,
    input  logic signed [WORD_SIZE-1:0] b_in,
    output logic signed [WORD_SIZE-1:0] a_out,
    output logic signed [WORD_SIZE-1:0] b_out,
    output logic signed [ACC_SIZE-1:0]  acc
`ifdef SMART_SYS_ACC_SAT_EN
    ,output logic                       sat
`endif
);

    logic signed [2*WORD_SIZE-1:0] prod;
    logic signed [ACC_SIZE-1:0]    prod_ext;
    logic signed [ACC_SIZE-1:0]    acc_nxt;

    assign prod     = a_in * b_in;
    assign prod_ext = ACC_SIZE'(prod);   // signed cast sign-extends

`ifdef SMART_SYS_ACC_SAT_EN
    localparam logic [127:0] MAX_W = acc_max_fn(ACC_SIZE);
    localparam logic [127:0] MIN_W = acc_min_fn(ACC_SIZE);
    localparam logic [ACC_SIZE-1:0] ACC_MAX = MAX_W[ACC_SIZE-1:0];
    localparam logic [ACC_SIZE-1:0] ACC_MIN = MIN_W[ACC_SIZE-1:0];

    logic [ACC_SIZE:0] sum_ext;
    assign sum_ext = {acc[ACC_SIZE-1], acc} + {prod_ext[ACC_SIZE-1], prod_ext};

    // Overflow when the guard bit disagrees with the result sign.
    always_comb begin
        sat     = 1'b0;
        acc_nxt = sum_ext[ACC_SIZE-1:0];
        if (sum_ext[ACC_SIZE] != sum_ext[ACC_SIZE-1]) begin
            sat     = en;
            acc_nxt = sum_ext[ACC_SIZE] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign acc_nxt = acc + prod_ext;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc_nxt;
        end
    end

endmodule

// File: rtl/smart_systolic_os_tile.sv
// Output-stationary systolic tile with input skewing and row readout.
// Optional feature macro: SMART_SYS_ACC_SAT_EN (saturating accumulate and
// sticky sat_flag_out port).
//   start_in/k_len_in : job start and reduction length (sampled in IDLE)
//   left_in_bus/top_in_bus/in_valid/in_ready : operand beat handshake
//   out_data/out_row_idx/out_valid/out_ready : result row handshake
//   busy_out : not IDLE;  done_out : final row handshake pulse
// Handshakes: a transfer happens on a rising clock edge where both valid
// and ready are high; valid never depends on ready in this block, and a
// presented result row stays stable until it transfers.
module smart_systolic_os_tile
    import smart_sys_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ACC_SIZE  = 40,
    parameter int NUM_ROWS  = 4,
    parameter int NUM_COLS  = 4,
    parameter int MAX_K     = 256,
    parameter int K_W       = $clog2(MAX_K + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_in,
    input  logic [K_W-1:0]                  k_len_in,
    input  logic [NUM_ROWS*WORD_SIZE-1:0]   left_in_bus,
    input  logic [NUM_COLS*WORD_SIZE-1:0]   top_in_bus,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [NUM_COLS*ACC_SIZE-1:0]    out_data,
    output logic [$clog2(NUM_ROWS)-1:0]     out_row_idx,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy_out,
    output logic                            done_out
`ifdef SMART_SYS_ACC_SAT_EN
    ,output logic                           sat_flag_out
`endif
);

    localparam int FLUSH_LEN = flush_len(NUM_ROWS, NUM_COLS);
    localparam int FL_W      = $clog2(FLUSH_LEN + 1);
    localparam int ROW_W     = $clog2(NUM_ROWS);

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_len_q, k_clamped, beat_cnt;
    logic [FL_W-1:0]    flush_cnt;
    logic [ROW_W-1:0]   row_cnt;
    logic               arr_en, clr;

    assign k_clamped = (k_len_in > K_W'(MAX_K)) ? K_W'(MAX_K) : k_len_in;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy_out  = 1'b1;
        done_out  = 1'b0;
        arr_en    = 1'b0;
        clr       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_out = 1'b0;
                if (start_in) begin
                    clr     = 1'b1;
                    state_d = (k_clamped == '0) ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                arr_en   = in_valid;
                if (in_valid && (beat_cnt == k_len_q - 1'b1)) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                arr_en = 1'b1;
                if (flush_cnt == FL_W'(FLUSH_LEN - 1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (row_cnt == ROW_W'(NUM_ROWS - 1))) begin
                    done_out = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- job counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_len_q   <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_cnt   <= '0;
        end else if (clr) begin
            k_len_q   <= k_clamped;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_cnt   <= '0;
        end else begin
            if (state_q == ST_LOAD && in_valid) beat_cnt <= beat_cnt + 1'b1;
            if (state_q == ST_FLUSH)            flush_cnt <= flush_cnt + 1'b1;
            if (state_q == ST_DRAIN && out_ready)
                row_cnt <= (row_cnt == ROW_W'(NUM_ROWS - 1)) ? '0 : row_cnt + 1'b1;
        end
    end

    // ---------------- skew + PE array ----------------
    logic signed [WORD_SIZE-1:0] a_link  [NUM_ROWS][NUM_COLS+1];
    logic signed [WORD_SIZE-1:0] b_link  [NUM_ROWS+1][NUM_COLS];
    logic signed [ACC_SIZE-1:0]  acc_arr [NUM_ROWS][NUM_COLS];
`ifdef SMART_SYS_ACC_SAT_EN
    logic [NUM_ROWS*NUM_COLS-1:0] sat_vec;
`endif

    // Zeros are injected outside LOAD so FLUSH pushes bubbles through.
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_left
        logic signed [WORD_SIZE-1:0] inj;
        assign inj = (state_q == ST_LOAD) ? left_in_bus[lane_lsb(r, WORD_SIZE) +: WORD_SIZE] : '0;
        if (r == 0) begin : g_direct
            assign a_link[r][0] = inj;
        end else begin : g_skew
            logic signed [WORD_SIZE-1:0] sr [r];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < r; i++) sr[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < r; i++) sr[i] <= '0;
                end else if (arr_en) begin
                    sr[0] <= inj;
                    for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
                end
            end
            assign a_link[r][0] = sr[r-1];
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_top
        logic signed [WORD_SIZE-1:0] inj;
        assign inj = (state_q == ST_LOAD) ? top_in_bus[lane_lsb(c, WORD_SIZE) +: WORD_SIZE] : '0;
        if (c == 0) begin : g_direct
            assign b_link[0][c] = inj;
        end else begin : g_skew
            logic signed [WORD_SIZE-1:0] sr [c];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < c; i++) sr[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < c; i++) sr[i] <= '0;
                end else if (arr_en) begin
                    sr[0] <= inj;
                    for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
                end
            end
            assign b_link[0][c] = sr[c-1];
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            smart_sys_os_pe #(
                .WORD_SIZE (WORD_SIZE),
                .ACC_SIZE  (ACC_SIZE)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .en    (arr_en),
                .clr   (clr),
                .a_in  (a_link[r][c]),
                .b_in  (b_link[r][c]),
                .a_out (a_link[r][c+1]),
                .b_out (b_link[r+1][c]),
                .acc   (acc_arr[r][c])
`ifdef SMART_SYS_ACC_SAT_EN
                ,.sat  (sat_vec[r*NUM_COLS+c])
`endif
            );
        end
    end

`ifdef SMART_SYS_ACC_SAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          sat_flag_out <= 1'b0;
        else if (clr)      sat_flag_out <= 1'b0;
        else if (|sat_vec) sat_flag_out <= 1'b1;
    end
`endif

    // ---------------- result readout ----------------
    assign out_row_idx = row_cnt;

    always_comb begin
        out_data = '0;
        if (state_q == ST_DRAIN) begin
            for (int c = 0; c < NUM_COLS; c++)
                out_data[c*ACC_SIZE +: ACC_SIZE] = acc_arr[row_cnt][c];
        end
    end

endmodule
